// File: rtl/range_uart_tx.sv
// range_uart_tx: captures a range-finder result on a one-cycle strobe. It sends the
// result as uppercase ASCII hex digits, MSB nibble first, followed by a line feed,
// over a UART TX line. An error result is sent as "E\n" instead.
//
// Ports:
//   clock     - system clock, all state updates on the rising edge
//   reset     - asynchronous active-high reset
//   range_in  - range result, WIDTH bits (N = WIDTH/4 hex digits)
//   error_in  - error flag from the range finder
//   capture   - one-cycle strobe, range_in/error_in valid this cycle
//   tx        - UART serial out, idle high, 8N1 (or 8E1, see below)
//   busy      - high while a message is in flight
//   overrun   - sticky, set when a capture arrives while busy
//
// Build option: define RANGE_TX_PARITY_EN to insert an even-parity bit between
// data bit 7 and the stop bit. This gives an 11-bit frame.
module range_uart_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] range_in,
    input  logic             error_in,
    input  logic             capture,
    output logic             tx,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned BW = $clog2(N + 1);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] BaudLast = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IdxLf    = BW'(N);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StStop   = 3'd3;
`ifdef RANGE_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd4;
`endif

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [BW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             err_q, err_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             ovr_q, ovr_d;

    logic             tick;
    logic [BW-1:0]    idx_last;

    // Message byte at index idx. Nibble idx is brought to the top by a left shift,
    // so no division is needed.
    function automatic logic [7:0] char_of(input logic [WIDTH-1:0] hold,
                                           input logic             err,
                                           input logic [BW-1:0]    idx);
        logic [WIDTH-1:0] sh;
        logic [3:0]       nib;
        logic [7:0]       c;
        sh  = hold << {idx, 2'b00};
        nib = 4'(sh >> (WIDTH - 4));
        if (err) begin
            c = (idx == '0) ? 8'h45 : 8'h0A;
        end else if (idx < IdxLf) begin
            c = (nib < 4'd10) ? {4'h3, nib} : {4'h4, nib - 4'd9};
        end else begin
            c = 8'h0A;
        end
        return c;
    endfunction

    assign tick     = (baud_q == BaudLast);
    assign idx_last = err_q ? BW'(1) : IdxLf;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        err_d   = err_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        baud_d  = (state_q == StIdle || tick) ? '0 : baud_q + 1'b1;

        if (capture && state_q != StIdle) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (capture) begin
                    hold_d  = range_in;
                    err_d   = error_in;
                    idx_d   = '0;
                    data_d  = char_of(range_in, error_in, '0);
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
`ifdef RANGE_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef RANGE_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (idx_q == idx_last) begin
                        state_d = StIdle;
                    end else begin
                        // Next byte starts right after this stop bit, with no idle gap.
                        idx_d   = idx_q + 1'b1;
                        data_d  = char_of(hold_q, err_q, idx_q + 1'b1);
                        state_d = StStart;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // tx is registered from next-state values, so the line is glitch-free and
        // changes on the same edge as the state.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_d[bit_d];
`ifdef RANGE_TX_PARITY_EN
            StParity: tx_d = ^data_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ovr_q   <= ovr_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = (state_q != StIdle);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_range_uart_tx.sv
// Directed testbench for range_uart_tx at WIDTH=8, CLKS_PER_BIT=4. A UART monitor
// decodes tx into a byte log, and the stimulus block checks the decoded bytes, the
// busy duration and the flag behaviour against hand-computed values.
module tb_range_uart_tx;

    localparam int C = 4;
`ifdef RANGE_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int STOPK = C * (FRAME - 1) + C / 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] range_in = 8'h00;
    logic       error_in = 1'b0;
    logic       capture = 1'b0;
    logic       tx;
    logic       busy;
    logic       overrun;

    int n_assert = 0;
    int n_fail   = 0;

    range_uart_tx #(
        .WIDTH        (8),
        .CLKS_PER_BIT (C)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .range_in (range_in),
        .error_in (error_in),
        .capture  (capture),
        .tx       (tx),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    // UART monitor: sampling at mid-bit, counted in cycles from the first start cycle.
    logic       mon_act = 1'b0;
    int         mon_k = 0;
    logic [7:0] mon_sh = 8'h00;
    logic       mon_par = 1'b0;
    logic [7:0] rx_log [64];
    logic       par_log [64];
    int         rx_n = 0;
    int         ferr = 0;
    int         busy_cnt = 0;

    always @(negedge clock) begin
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (reset) begin
            mon_act <= 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act <= 1'b1;
                mon_k   <= 1;
            end
        end else begin
            mon_k <= mon_k + 1;
            if (mon_k == C / 2 && tx !== 1'b0) ferr <= ferr + 1;
            for (int i = 0; i < 8; i++) begin
                if (mon_k == C * (i + 1) + C / 2) mon_sh[i] <= tx;
            end
            if (mon_k == C * 9 + C / 2) mon_par <= tx;
            if (mon_k == STOPK) begin
                if (tx !== 1'b1) ferr <= ferr + 1;
                rx_log[rx_n[5:0]]  <= mon_sh;
                par_log[rx_n[5:0]] <= mon_par;
                rx_n    <= rx_n + 1;
                mon_act <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; applies a one-cycle capture strobe and returns at the next
    // negedge, which is the first cycle of the start bit.
    task automatic send(input logic [7:0] r, input logic e);
        range_in = r;
        error_in = e;
        capture  = 1'b1;
        @(negedge clock);
        capture  = 1'b0;
    endtask

    // Returns at the first negedge with busy low, within a bounded number of cycles.
    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        chk({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_msg(input string tag, input int n0, input int b0, input int nb,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] e;
        chk({tag, "_nbytes"}, rx_n - n0, nb);
        for (int i = 0; i < nb; i++) begin
            e = (i == 0) ? e0 : (i == 1) ? e1 : e2;
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, rx_log[(n0 + i) % 64]}, {24'd0, e});
        end
        chk({tag, "_busy_cycles"}, busy_cnt - b0, nb * FRAME * C);
    endtask

    int n0;
    int b0;

    initial begin
        // Reset state, held and after release
        repeat (2) @(negedge clock);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("post_rst_tx", {31'd0, tx}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // 0x3C -> "3C\n"
        n0 = rx_n; b0 = busy_cnt;
        send(8'h3C, 1'b0);
        chk("t1_tx_start", {31'd0, tx}, 32'd0);
        chk("t1_busy_rise", {31'd0, busy}, 32'd1);
        wait_idle("t1");
        chk_msg("t1", n0, b0, 3, 8'h33, 8'h43, 8'h0A);
`ifdef RANGE_TX_PARITY_EN
        chk("t1_par0", {31'd0, par_log[(n0 + 0) % 64]}, 32'd0);
        chk("t1_par1", {31'd0, par_log[(n0 + 1) % 64]}, 32'd1);
        chk("t1_par2", {31'd0, par_log[(n0 + 2) % 64]}, 32'd0);
`endif
        chk("t1_overrun", {31'd0, overrun}, 32'd0);

        // Error result ignores range
        repeat (3) @(negedge clock);
        n0 = rx_n; b0 = busy_cnt;
        send(8'hA5, 1'b1);
        wait_idle("t2");
        chk_msg("t2", n0, b0, 2, 8'h45, 8'h0A, 8'h00);

        // Boundary values
        repeat (3) @(negedge clock);
        n0 = rx_n; b0 = busy_cnt;
        send(8'h00, 1'b0);
        wait_idle("t3");
        chk_msg("t3", n0, b0, 3, 8'h30, 8'h30, 8'h0A);

        repeat (3) @(negedge clock);
        n0 = rx_n; b0 = busy_cnt;
        send(8'hFF, 1'b0);
        wait_idle("t4");
        chk_msg("t4", n0, b0, 3, 8'h46, 8'h46, 8'h0A);

        // Capture while busy: flagged, ignored, sticky
        repeat (3) @(negedge clock);
        n0 = rx_n; b0 = busy_cnt;
        send(8'h3C, 1'b0);
        repeat (19) @(negedge clock);
        range_in = 8'hFF;
        capture  = 1'b1;
        @(negedge clock);
        capture  = 1'b0;
        chk("t5_overrun_set", {31'd0, overrun}, 32'd1);
        wait_idle("t5");
        chk_msg("t5", n0, b0, 3, 8'h33, 8'h43, 8'h0A);
        repeat (50) @(negedge clock);
        chk("t5_no_second_msg", rx_n - n0, 3);
        chk("t5_busy_stays_low", {31'd0, busy}, 32'd0);
        chk("t5_overrun_sticky", {31'd0, overrun}, 32'd1);

        // Capture on the busy-fall cycle starts the next message at once
        n0 = rx_n; b0 = busy_cnt;
        send(8'h12, 1'b0);
        wait_idle("t6a");
        send(8'hA9, 1'b0);
        chk("t6_tx_start", {31'd0, tx}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd1);
        wait_idle("t6b");
        chk("t6_nbytes", rx_n - n0, 6);
        chk("t6_b0", {24'd0, rx_log[(n0 + 0) % 64]}, 32'h31);
        chk("t6_b1", {24'd0, rx_log[(n0 + 1) % 64]}, 32'h32);
        chk("t6_b2", {24'd0, rx_log[(n0 + 2) % 64]}, 32'h0A);
        chk("t6_b3", {24'd0, rx_log[(n0 + 3) % 64]}, 32'h41);
        chk("t6_b4", {24'd0, rx_log[(n0 + 4) % 64]}, 32'h39);
        chk("t6_b5", {24'd0, rx_log[(n0 + 5) % 64]}, 32'h0A);
        chk("t6_busy_cycles", busy_cnt - b0, 6 * FRAME * C);

        // Reset during data bit 3 of the first byte ('3' = 0x33, bit 3 is 0)
        repeat (3) @(negedge clock);
        send(8'h3C, 1'b0);
        repeat (17) @(negedge clock);
        chk("t7_bit3_low", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        #1;
        chk("t7_async_tx", {31'd0, tx}, 32'd1);
        chk("t7_async_busy", {31'd0, busy}, 32'd0);
        chk("t7_async_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("t7_idle_after_rst", {31'd0, busy}, 32'd0);
        n0 = rx_n; b0 = busy_cnt;
        send(8'h07, 1'b0);
        wait_idle("t7");
        chk_msg("t7", n0, b0, 3, 8'h30, 8'h37, 8'h0A);

        chk("framing_errors", ferr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
